// File: rtl/proc_run_controller_pkg.sv
// Shared state encoding and defaults for the processor run controller.
package proc_ctrl_pkg;

   localparam int          STATE_W           = 3;
   localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RSTCPU = 3'd2,
      ST_READY  = 3'd3,
      ST_RUN    = 3'd4,
      ST_STEP   = 3'd5,
      ST_HALTED = 3'd6
   } state_t;

endpackage

// File: rtl/proc_run_controller_if.sv
// Program load stream and instruction-memory write port between host, controller and imem.
interface proc_run_controller_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              load_valid;
   logic              load_ready;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;

   modport master (
      output load_valid, load_data, load_last,
      input  load_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  load_valid, load_data, load_last,
      output load_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/proc_run_controller_prog_loader.sv
// Program loader: beat handshake, word address counter, registered imem write port, overflow flag.
// The write lands one cycle after acceptance; ready is decoded from FSM state by the parent.
module prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic              load_ready,
   input  logic              load_last,
   input  logic [DATA_W-1:0] load_data,
   input  logic              fresh,
   output logic              accept,
   output logic              done,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              load_err
);

   localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] base_addr;
   logic              at_top;

   // A new program always starts at word 0; otherwise continue after the previous beat.
   always_comb begin
      accept    = load_valid && load_ready;
      base_addr = fresh ? '0 : next_addr;
      at_top    = (base_addr == TOP_ADDR);
      done      = accept && (load_last || at_top);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         next_addr  <= '0;
         load_err   <= 1'b0;
      end else begin
         imem_we <= accept;
         if (accept) begin
            imem_addr  <= base_addr;
            imem_wdata <= load_data;
            next_addr  <= base_addr + 1'b1;
         end
         if (accept && at_top && !load_last) begin
            load_err <= 1'b1;
         end else if (accept && fresh) begin
            load_err <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/proc_run_controller.sv
// Run controller: loads imem, holds the CPU in reset, then gates cpu_en for run/step/pause.
// Optional breakpoint comparator enabled by defining PROC_CTRL_BREAKPOINT_EN.
module proc_run_controller
   import proc_ctrl_pkg::*;
#(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(DEFAULT_HALT_WORD),
   parameter int unsigned       RST_CYCLES = 2,
   parameter int unsigned       MAX_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   proc_run_controller_if.slave bus,
   input  logic                 cmd_run,
   input  logic                 cmd_step,
   input  logic                 cmd_halt,
   input  logic [31:0]          cpu_pc,
   input  logic [DATA_W-1:0]    cpu_instr,
`ifdef PROC_CTRL_BREAKPOINT_EN
   input  logic                 bp_valid,
   input  logic [31:0]          bp_addr,
`endif
   output logic                 cpu_rst,
   output logic                 cpu_en,
   output logic [STATE_W-1:0]   state,
   output logic                 halted,
   output logic                 timeout,
   output logic                 load_err,
   output logic [31:0]          cycle_count
);

   localparam int          RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [31:0] WD_LIMIT = 32'(MAX_CYCLES);

   state_t          cur;
   state_t          nxt;
   logic [RC_W-1:0] rst_cnt;
   logic            accept;
   logic            done;
   logic            fresh;
   logic            is_halt;
   logic            bp_hit;
   logic            wd_trip;
   logic [31:0]     cc_inc;

   assign state          = cur;
   assign fresh          = (cur == ST_IDLE) || (cur == ST_HALTED);
   assign bus.load_ready = (cur == ST_IDLE) || (cur == ST_LOAD) || (cur == ST_HALTED);
   assign cpu_rst        = (cur == ST_IDLE) || (cur == ST_LOAD) || (cur == ST_RSTCPU);
   assign halted         = (cur == ST_HALTED);
   assign is_halt        = (cpu_instr == HALT_WORD);
   assign cc_inc         = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

`ifdef PROC_CTRL_BREAKPOINT_EN
   // Set when a breakpoint stops RUN so the next enabled cycle steps over it.
   logic bp_skip;
   assign bp_hit = (cur == ST_RUN) && bp_valid && (cpu_pc == bp_addr) && !bp_skip;

   always_ff @(posedge clk) begin
      if (!rst) begin
         bp_skip <= 1'b0;
      end else if (bp_hit) begin
         bp_skip <= 1'b1;
      end else if (cpu_en || (nxt == ST_RSTCPU)) begin
         bp_skip <= 1'b0;
      end
   end
`else
   logic unused_pc;
   assign bp_hit    = 1'b0;
   assign unused_pc = ^cpu_pc;
`endif

   prog_loader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_loader (
      .clk        (clk),
      .rst        (rst),
      .load_valid (bus.load_valid),
      .load_ready (bus.load_ready),
      .load_last  (bus.load_last),
      .load_data  (bus.load_data),
      .fresh      (fresh),
      .accept     (accept),
      .done       (done),
      .imem_we    (bus.imem_we),
      .imem_addr  (bus.imem_addr),
      .imem_wdata (bus.imem_wdata),
      .load_err   (load_err)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur <= ST_IDLE;
      end else begin
         cur <= nxt;
      end
   end

   always_comb begin
      nxt     = cur;
      cpu_en  = 1'b0;
      wd_trip = 1'b0;
      case (cur)
         ST_IDLE, ST_HALTED: begin
            if (accept) begin
               nxt = done ? ST_RSTCPU : ST_LOAD;
            end else if (cmd_run) begin
               nxt = ST_RSTCPU;
            end
         end
         ST_LOAD: begin
            if (done) nxt = ST_RSTCPU;
         end
         ST_RSTCPU: begin
            if (rst_cnt == RC_W'(RST_CYCLES - 1)) nxt = ST_READY;
         end
         ST_READY: begin
            if (cmd_step) begin
               nxt = ST_STEP;
            end else if (cmd_run) begin
               nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            // Halt word is never executed: enable drops in the same cycle it is seen.
            cpu_en  = !cmd_halt && !is_halt && !bp_hit;
            wd_trip = cpu_en && (cc_inc >= WD_LIMIT);
            if (cmd_halt || bp_hit) begin
               nxt = ST_READY;
            end else if (is_halt || wd_trip) begin
               nxt = ST_HALTED;
            end
         end
         ST_STEP: begin
            cpu_en  = !is_halt;
            wd_trip = cpu_en && (cc_inc >= WD_LIMIT);
            nxt     = (is_halt || wd_trip) ? ST_HALTED : ST_READY;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_cnt     <= '0;
         cycle_count <= '0;
         timeout     <= 1'b0;
      end else begin
         rst_cnt <= (cur == ST_RSTCPU) ? rst_cnt + 1'b1 : '0;
         if (nxt == ST_RSTCPU) begin
            cycle_count <= '0;
         end else if (cpu_en) begin
            cycle_count <= cc_inc;
         end
         if (wd_trip) begin
            timeout <= 1'b1;
         end else if (accept && fresh) begin
            timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_proc_run_controller.sv
// Directed bench for proc_run_controller with a tiny PC/imem model standing in for the processor.
module tb_proc_run_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_run, cmd_step, cmd_halt;
   logic [31:0] cpu_pc;
   logic [31:0] cpu_instr;
   logic        cpu_rst, cpu_en, halted, timeout, load_err;
   logic [2:0]  state;
   logic [31:0] cycle_count;
`ifdef PROC_CTRL_BREAKPOINT_EN
   logic        bp_valid;
   logic [31:0] bp_addr;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   proc_run_controller_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   proc_run_controller #(
      .ADDR_W     (8),
      .DATA_W     (32),
      .HALT_WORD  (32'h0000_000C),
      .RST_CYCLES (2),
      .MAX_CYCLES (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .cmd_run     (cmd_run),
      .cmd_step    (cmd_step),
      .cmd_halt    (cmd_halt),
      .cpu_pc      (cpu_pc),
      .cpu_instr   (cpu_instr),
`ifdef PROC_CTRL_BREAKPOINT_EN
      .bp_valid    (bp_valid),
      .bp_addr     (bp_addr),
`endif
      .cpu_rst     (cpu_rst),
      .cpu_en      (cpu_en),
      .state       (state),
      .halted      (halted),
      .timeout     (timeout),
      .load_err    (load_err),
      .cycle_count (cycle_count)
   );

   // Processor stand-in: PC advances by 4 per enabled cycle, instruction fetched from written imem.
   logic [31:0] mem [256];
   assign cpu_instr = mem[cpu_pc[9:2]];
   always @(posedge clk) begin
      if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;
      if (cpu_rst) cpu_pc <= 32'd0;
      else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
   end

   typedef struct {
      logic [31:0] lv, ld, ll, run, step, hlt;
      logic [31:0] st, en, crst, rdy, we, addr, cc, pc;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.load_valid = 1'b0;
      bus.load_data  = 32'd0;
      bus.load_last  = 1'b0;
      cmd_run        = 1'b0;
      cmd_step       = 1'b0;
      cmd_halt       = 1'b0;
   endtask

   initial begin
      //           lv  data          ll run stp hlt  st en rst rdy we adr cc pc
      vecs = '{
         '{32'd1, 32'h2008_0005, 32'd0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0},
         '{32'd1, 32'h2009_0003, 32'd0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 0, 0},
         '{32'd1, 32'h0000_000C, 32'd1, 0, 0, 0,  1, 0, 1, 1, 1, 1, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  2, 0, 1, 0, 1, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  2, 0, 1, 0, 0, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 1, 0, 0,  3, 0, 0, 0, 0, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  4, 1, 0, 0, 0, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  4, 1, 0, 0, 0, 2, 1, 4},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  4, 0, 0, 0, 0, 2, 2, 8},
         '{32'd0, 32'h0,         32'd0, 0, 1, 0,  6, 0, 0, 1, 0, 2, 2, 8},
         '{32'd0, 32'h0,         32'd0, 1, 0, 0,  6, 0, 0, 1, 0, 2, 2, 8},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  2, 0, 1, 0, 0, 2, 0, 8},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  2, 0, 1, 0, 0, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 1, 0,  3, 0, 0, 0, 0, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  5, 1, 0, 0, 0, 2, 0, 0},
         '{32'd0, 32'h0,         32'd0, 0, 0, 1,  3, 0, 0, 0, 0, 2, 1, 4},
         '{32'd0, 32'h0,         32'd0, 0, 1, 0,  3, 0, 0, 0, 0, 2, 1, 4},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  5, 1, 0, 0, 0, 2, 1, 4},
         '{32'd0, 32'h0,         32'd0, 0, 1, 0,  3, 0, 0, 0, 0, 2, 2, 8},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  5, 0, 0, 0, 0, 2, 2, 8},
         '{32'd0, 32'h0,         32'd0, 0, 0, 0,  6, 0, 0, 1, 0, 2, 2, 8}
      };

      idle_inputs();
`ifdef PROC_CTRL_BREAKPOINT_EN
      bp_valid = 1'b0;
      bp_addr  = 32'd0;
`endif
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset timeout",  32'(timeout),  0);
      chk("reset load_err", 32'(load_err), 0);
      chk("reset halted",   32'(halted),   0);
      chk("reset wdata",    bus.imem_wdata, 0);

      // Load 3-word program, restart, run to halt, then single-step twice.
      for (int i = 0; i < 21; i++) begin
         bus.load_valid = vecs[i].lv[0];
         bus.load_data  = vecs[i].ld;
         bus.load_last  = vecs[i].ll[0];
         cmd_run        = vecs[i].run[0];
         cmd_step       = vecs[i].step[0];
         cmd_halt       = vecs[i].hlt[0];
         #1;
         chk($sformatf("row%0d state", i),  32'(state),          vecs[i].st);
         chk($sformatf("row%0d cpu_en", i), 32'(cpu_en),         vecs[i].en);
         chk($sformatf("row%0d cpu_rst", i), 32'(cpu_rst),       vecs[i].crst);
         chk($sformatf("row%0d ready", i),  32'(bus.load_ready), vecs[i].rdy);
         chk($sformatf("row%0d we", i),     32'(bus.imem_we),    vecs[i].we);
         chk($sformatf("row%0d addr", i),   32'(bus.imem_addr),  vecs[i].addr);
         chk($sformatf("row%0d cc", i),     cycle_count,         vecs[i].cc);
         chk($sformatf("row%0d pc", i),     cpu_pc,              vecs[i].pc);
         chk($sformatf("row%0d halted", i), 32'(halted),         (vecs[i].st == 6) ? 1 : 0);
         tick();
      end
      idle_inputs();
      #1;
      chk("halt-word stop timeout", 32'(timeout), 0);

      // 256 beats without last: overflow on the final word.
      for (int i = 0; i < 256; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 32'h1000_0000 | 32'(i);
         #1;
         chk($sformatf("ovf beat%0d ready", i), 32'(bus.load_ready), 1);
         tick();
      end
      idle_inputs();
      #1;
      chk("ovf state",    32'(state),         2);
      chk("ovf load_err", 32'(load_err),      1);
      chk("ovf we",       32'(bus.imem_we),   1);
      chk("ovf addr",     32'(bus.imem_addr), 255);
      chk("ovf wdata",    bus.imem_wdata,     32'h1000_00FF);
      tick();
      #1 chk("ovf rstcpu hold", 32'(state), 2);
      tick();
      #1 chk("ovf ready", 32'(state), 3);

      // Pause mid-run, resume, then watchdog expiry at 10 enabled cycles.
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      #1 chk("wd run cc0", cycle_count, 0);
      repeat (3) tick();
      cmd_halt = 1'b1;
      #1;
      chk("pause cpu_en", 32'(cpu_en), 0);
      chk("pause state",  32'(state),  4);
      tick();
      cmd_halt = 1'b0;
      #1;
      chk("paused state", 32'(state), 3);
      chk("paused cc",    cycle_count, 3);
      chk("paused pc",    cpu_pc, 12);
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk($sformatf("wd cyc%0d state", i), 32'(state), 4);
         chk($sformatf("wd cyc%0d en", i),    32'(cpu_en), 1);
         tick();
      end
      #1;
      chk("wd state",   32'(state),   6);
      chk("wd timeout", 32'(timeout), 1);
      chk("wd cc",      cycle_count,  10);
      chk("wd halted",  32'(halted),  1);
      chk("wd pc",      cpu_pc,       40);

      // Restart keeps sticky flags; reset during run clears everything.
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      #1;
      chk("restart state",    32'(state),    2);
      chk("restart timeout",  32'(timeout),  1);
      chk("restart load_err", 32'(load_err), 1);
      chk("restart cc",       cycle_count,   0);
      repeat (2) tick();
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      repeat (5) tick();
      #1 chk("mid-run cc", cycle_count, 5);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rst state",    32'(state),    0);
      chk("rst cpu_rst",  32'(cpu_rst),  1);
      chk("rst cc",       cycle_count,   0);
      chk("rst timeout",  32'(timeout),  0);
      chk("rst load_err", 32'(load_err), 0);
      chk("rst ready",    32'(bus.load_ready), 1);

      // In IDLE a load beat wins over cmd_run.
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hAAAA_0001;
      cmd_run        = 1'b1;
      tick();
      cmd_run        = 1'b0;
      bus.load_data  = 32'h2009_0003;
      bus.load_last  = 1'b1;
      #1;
      chk("prio state", 32'(state),         1);
      chk("prio addr",  32'(bus.imem_addr), 0);
      tick();
      idle_inputs();
      #1;
      chk("short load state", 32'(state),         2);
      chk("short load addr",  32'(bus.imem_addr), 1);
      repeat (2) tick();
      #1 chk("short load ready", 32'(state), 3);

      rst = 1'b0;
      tick();
      rst = 1'b1;
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      #1 chk("idle run state", 32'(state), 2);

`ifdef PROC_CTRL_BREAKPOINT_EN
      repeat (2) tick();
      bp_valid = 1'b1;
      bp_addr  = 32'd4;
      cmd_run  = 1'b1;
      tick();
      cmd_run  = 1'b0;
      #1 chk("bp first en", 32'(cpu_en), 1);
      tick();
      #1 chk("bp hit en", 32'(cpu_en), 0);
      tick();
      #1;
      chk("bp state", 32'(state), 3);
      chk("bp pc",    cpu_pc,     4);
      chk("bp cc",    cycle_count, 1);
      cmd_run = 1'b1;
      tick();
      cmd_run = 1'b0;
      #1 chk("bp resume en", 32'(cpu_en), 1);
      tick();
      #1 chk("bp resume pc", cpu_pc, 8);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
